// File: rtl/ifu_prefetch_buf.sv
// ifu_prefetch_buf: instruction prefetch buffer between the instruction
// memory port and the IF stage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid_o/ready_i : sequential fetch request handshake, address req_addr_o
//   rsp_valid_i         : in-order response (always accepted) with
//                         rsp_data_i and the access-fault flag rsp_err_i
//   instr_valid_o/ready_i : FIFO head handshake toward IF, with
//                         instr_o, pc_o and err_o
//   jmp_en_i, jmp_to_i  : redirect; flushes queued and in-flight fetches
module ifu_prefetch_buf #(
  parameter int ADDR_W          = 64,
  parameter int INSTR_W         = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               req_valid_o,
  input  logic               req_ready_i,
  output logic [ADDR_W-1:0]  req_addr_o,
  input  logic               rsp_valid_i,
  input  logic [INSTR_W-1:0] rsp_data_i,
  input  logic               rsp_err_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               err_o,
  input  logic               jmp_en_i,
  input  logic [ADDR_W-1:0]  jmp_to_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  disc_q, disc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

  logic [DEPTH-1:0][INSTR_W-1:0] instr_mem_q;
  logic [DEPTH-1:0][ADDR_W-1:0]  pc_mem_q;
  logic [DEPTH-1:0]              err_mem_q;

  logic [CNT_W-1:0] live;
  logic             credit_ok;
  logic             req_accept;
  logic             rsp_drop;
  logic             rsp_push;
  logic             pop;

  // Live in-flight responses reserve FIFO slots, so a push never finds it full.
  assign live      = outst_q - disc_q;
  assign credit_ok = ({1'b0, count_q} + {1'b0, live}) < (CNT_W + 1)'(DEPTH);

  assign req_valid_o = !jmp_en_i && (outst_q < CNT_W'(MAX_OUTSTANDING)) && credit_ok;
  assign req_addr_o  = fetch_pc_q;
  assign req_accept  = req_valid_o && req_ready_i;

  assign rsp_drop = rsp_valid_i && (disc_q != '0);
  assign rsp_push = rsp_valid_i && (disc_q == '0) && !jmp_en_i;

  assign instr_valid_o = (count_q != '0);
  assign pop           = instr_valid_o && instr_ready_i && !jmp_en_i;

  assign instr_o = instr_mem_q[rd_ptr_q];
  assign pc_o    = pc_mem_q[rd_ptr_q];
  assign err_o   = err_mem_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    disc_d     = disc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (jmp_en_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = jmp_to_i;
      rsp_pc_d   = jmp_to_i;
      outst_d    = outst_q - CNT_W'(rsp_valid_i);
      disc_d     = outst_q - CNT_W'(rsp_valid_i);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_accept) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      outst_d = outst_q + CNT_W'(req_accept) - CNT_W'(rsp_valid_i);
      if (rsp_drop) begin
        disc_d = disc_q - CNT_W'(1);
      end
      if (rsp_push) begin
        rsp_pc_d = rsp_pc_q + ADDR_W'(4);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(rsp_push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      outst_q     <= '0;
      disc_q      <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      instr_mem_q <= '0;
      pc_mem_q    <= '0;
      err_mem_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (rsp_push) begin
        instr_mem_q[wr_ptr_q] <= rsp_data_i;
        pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
        err_mem_q[wr_ptr_q]   <= rsp_err_i;
      end
    end
  end

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
// tb_ifu_prefetch_buf: randomized scoreboard bench for ifu_prefetch_buf.
// A behavioural memory answers requests in order; the expected instruction
// stream is the sequential PC path from the last reset/redirect target.
module tb_ifu_prefetch_buf;

  localparam int          ADDR_W  = 64;
  localparam int          INSTR_W = 32;
  localparam int          DEPTH   = 4;
  localparam int          MAXO    = 2;
  localparam logic [63:0] RST_PC  = 64'h8000_0000;

  logic               clk;
  logic               rst_n;
  logic               req_valid_o;
  logic               req_ready_i;
  logic [ADDR_W-1:0]  req_addr_o;
  logic               rsp_valid_i;
  logic [INSTR_W-1:0] rsp_data_i;
  logic               rsp_err_i;
  logic               instr_valid_o;
  logic               instr_ready_i;
  logic [INSTR_W-1:0] instr_o;
  logic [ADDR_W-1:0]  pc_o;
  logic               err_o;
  logic               jmp_en_i;
  logic [ADDR_W-1:0]  jmp_to_i;

  ifu_prefetch_buf #(
    .ADDR_W(ADDR_W),
    .INSTR_W(INSTR_W),
    .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC(RST_PC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i),
    .req_addr_o(req_addr_o),
    .rsp_valid_i(rsp_valid_i),
    .rsp_data_i(rsp_data_i),
    .rsp_err_i(rsp_err_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o(instr_o),
    .pc_o(pc_o),
    .err_o(err_o),
    .jmp_en_i(jmp_en_i),
    .jmp_to_i(jmp_to_i)
  );

  typedef struct {
    logic [63:0] addr;
    bit          stale;
  } req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    bit          err;
  } exp_t;

  req_t        pend[$];
  exp_t        sb[$];
  logic [63:0] model_pc;
  int          errors  = 0;
  int          checks  = 0;
  int          accepts = 0;
  int          pops    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit err_fn(input logic [63:0] a);
    return (a == 64'h8000_0008) || (a[7:2] == 6'h2b);
  endfunction

  // Monitor: compares the FIFO head against the scoreboard every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        chk("instr_valid", 64'(instr_valid_o), 64'(sb.size() != 0));
        if (instr_valid_o && sb.size() != 0) begin
          chk("pc_o", pc_o, sb[0].pc);
          chk("instr_o", 64'(instr_o), 64'(sb[0].instr));
          chk("err_o", 64'(err_o), 64'(sb[0].err));
        end
        if (jmp_en_i) begin
          sb.delete();
        end else if (instr_valid_o && instr_ready_i && sb.size() != 0) begin
          void'(sb.pop_front());
          pops++;
        end
      end
    end
  end

  // One clock cycle: drive at negedge, check request side, then advance the model.
  task automatic step(input bit jmp, input logic [63:0] tgt, input int reqr_pct,
                      input int rsp_pct, input int ifr_pct);
    bit   exp_rv;
    int   live;
    req_t r;
    @(negedge clk);
    jmp_en_i      = jmp;
    jmp_to_i      = tgt;
    req_ready_i   = ($urandom_range(99) < reqr_pct);
    instr_ready_i = ($urandom_range(99) < ifr_pct);
    if (pend.size() != 0 && $urandom_range(99) < rsp_pct) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = pend[0].addr[31:0];
      rsp_err_i   = err_fn(pend[0].addr);
    end else begin
      rsp_valid_i = 1'b0;
      rsp_data_i  = $urandom;
      rsp_err_i   = 1'($urandom_range(1));
    end
    #2;
    live = 0;
    foreach (pend[i]) if (!pend[i].stale) live++;
    exp_rv = !jmp && (pend.size() < MAXO) && ((sb.size() + live) < DEPTH);
    chk("req_valid", 64'(req_valid_o), 64'(exp_rv));
    if (req_valid_o) chk("req_addr", req_addr_o, model_pc);
    #2;
    if (rsp_valid_i) begin
      r = pend.pop_front();
      if (!jmp && !r.stale) sb.push_back('{r.addr, r.addr[31:0], err_fn(r.addr)});
    end
    if (jmp) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      model_pc = tgt;
    end else if (req_valid_o && req_ready_i) begin
      pend.push_back('{model_pc, 1'b0});
      model_pc = model_pc + 64'd4;
      accepts++;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs checked before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n         = 1'b0;
    rsp_valid_i   = 1'b0;
    jmp_en_i      = 1'b0;
    req_ready_i   = 1'b0;
    instr_ready_i = 1'b0;
    #1;
    chk("rst instr_valid", 64'(instr_valid_o), 64'd0);
    chk("rst instr_o", 64'(instr_o), 64'd0);
    chk("rst pc_o", pc_o, 64'd0);
    chk("rst err_o", 64'(err_o), 64'd0);
    chk("rst req_valid", 64'(req_valid_o), 64'd1);
    chk("rst req_addr", req_addr_o, RST_PC);
    pend.delete();
    sb.delete();
    model_pc = RST_PC;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] tgt;
    int          guard;
    rst_n         = 1'b0;
    req_ready_i   = 1'b0;
    rsp_valid_i   = 1'b0;
    rsp_data_i    = '0;
    rsp_err_i     = 1'b0;
    instr_ready_i = 1'b0;
    jmp_en_i      = 1'b0;
    jmp_to_i      = '0;
    model_pc      = RST_PC;
    repeat (2) @(posedge clk);
    do_reset();

    // Streaming with a 1-cycle memory: one instruction per cycle.
    pops = 0;
    repeat (40) step(1'b0, '0, 100, 100, 100);
    chk("throughput", 64'(pops >= 35), 64'd1);

    // Redirect with two in flight, one answering in the redirect cycle.
    guard = 0;
    while (pend.size() < 2 && guard < 8) begin
      step(1'b0, '0, 100, 0, 100);
      guard++;
    end
    chk("two outstanding", 64'(pend.size()), 64'd2);
    step(1'b1, 64'h8000_0100, 100, 100, 100);
    repeat (30) step(1'b0, '0, 100, 100, 100);

    // Reset mid-stream with two requests outstanding.
    guard = 0;
    while (pend.size() < 2 && guard < 8) begin
      step(1'b0, '0, 100, 0, 100);
      guard++;
    end
    chk("two outstanding pre-reset", 64'(pend.size()), 64'd2);
    do_reset();

    // Stalled IF: exactly DEPTH requests accepted, then fetch stops.
    accepts = 0;
    repeat (20) step(1'b0, '0, 100, 100, 0);
    chk("stall accepts", 64'(accepts), 64'(DEPTH));
    chk("stall req_valid", 64'(req_valid_o), 64'd0);
    pops = 0;
    repeat (4) step(1'b0, '0, 0, 100, 100);
    chk("stall drain pops", 64'(pops), 64'(DEPTH));

    // Randomized traffic with redirects, including unaligned and wrapping targets.
    for (int unsigned n = 0; n < 1500; n++) begin
      if ($urandom_range(99) < 4) begin
        case ($urandom_range(3))
          0:       tgt = 64'hFFFF_FFFF_FFFF_FFF8;
          1:       tgt = {$urandom, $urandom};
          default: tgt = {32'h0, $urandom} & ~64'h3;
        endcase
        step(1'b1, tgt, $urandom_range(100), $urandom_range(100), $urandom_range(100));
      end else begin
        step(1'b0, '0, $urandom_range(100), $urandom_range(100), $urandom_range(100));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
